// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Optional ALU_ARB_LOCK_EN adds req0_lock/req1_lock so a requester can keep priority across ops.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
`ifdef ALU_ARB_LOCK_EN
  input  logic             req0_lock,
  input  logic             req1_lock,
`endif
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_f,
  output logic             rsp0_zf,
  output logic             rsp0_of,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_f,
  output logic             rsp1_zf,
  output logic             rsp1_of,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_f,
  input  logic             alu_zf,
  input  logic             alu_of
);

  localparam int unsigned LAST_LEGAL_OP = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_owner;
  logic             r_last_grant;
  logic [OPW-1:0]   r_alu_op;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [WIDTH-1:0] r_f;
  logic             r_zf;
  logic             r_of;

  logic w_grant_id;
  logic w_req_hs;
  logic w_rsp_hs;
  logic w_illegal;
  logic w_update_last;

  // Tie goes to the requester that was not served last; rst_n gating keeps ready low in reset.
  always_comb begin
    w_grant_id = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    w_req_hs   = (r_state == ST_IDLE) && rst_n && (req0_valid || req1_valid);
    w_rsp_hs   = (r_state == ST_RESP) && (r_owner ? rsp1_ready : rsp0_ready);
    w_illegal  = (r_alu_op > OPW'(LAST_LEGAL_OP));
  end

`ifdef ALU_ARB_LOCK_EN
  logic r_lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock <= 1'b0;
    end else if (w_req_hs) begin
      r_lock <= w_grant_id ? req1_lock : req0_lock;
    end
  end

  assign w_update_last = ~r_lock;
`else
  assign w_update_last = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_req_hs) w_next_state = ST_EXEC;
      ST_EXEC: w_next_state = ST_RESP;
      ST_RESP: if (w_rsp_hs) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    if (w_req_hs) begin
      req0_ready = ~w_grant_id;
      req1_ready = w_grant_id;
    end
    if (r_state == ST_RESP) begin
      rsp0_valid = ~r_owner;
      rsp1_valid = r_owner;
    end
  end

  // Operand latch, result capture and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_alu_op     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_f          <= '0;
      r_zf         <= 1'b0;
      r_of         <= 1'b0;
    end else begin
      if (w_req_hs) begin
        r_owner  <= w_grant_id;
        r_alu_op <= w_grant_id ? req1_op : req0_op;
        r_alu_a  <= w_grant_id ? req1_a : req0_a;
        r_alu_b  <= w_grant_id ? req1_b : req0_b;
      end
      if (r_state == ST_EXEC) begin
        if (w_illegal) begin
          r_f  <= '0;
          r_zf <= 1'b1;
          r_of <= 1'b0;
        end else begin
          r_f  <= alu_f;
          r_zf <= alu_zf;
          r_of <= alu_of;
        end
      end
      if (w_rsp_hs && w_update_last) begin
        r_last_grant <= r_owner;
      end
    end
  end

  assign alu_op  = r_alu_op;
  assign alu_a   = r_alu_a;
  assign alu_b   = r_alu_b;
  assign rsp0_f  = r_f;
  assign rsp0_zf = r_zf;
  assign rsp0_of = r_of;
  assign rsp1_f  = r_f;
  assign rsp1_zf = r_zf;
  assign rsp1_of = r_of;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_alu_arbiter;
  localparam int unsigned W   = 32;
  localparam int unsigned OPW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OPW-1:0] req0_op, req1_op;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           rsp0_valid, rsp0_ready, rsp0_zf, rsp0_of;
  logic           rsp1_valid, rsp1_ready, rsp1_zf, rsp1_of;
  logic [W-1:0]   rsp0_f, rsp1_f;
  logic [OPW-1:0] alu_op;
  logic [W-1:0]   alu_a, alu_b, alu_f;
  logic           alu_zf, alu_of;
`ifdef ALU_ARB_LOCK_EN
  logic           req0_lock, req1_lock;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
`ifdef ALU_ARB_LOCK_EN
    .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_f(rsp0_f), .rsp0_zf(rsp0_zf), .rsp0_of(rsp0_of),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_f(rsp1_f), .rsp1_zf(rsp1_zf), .rsp1_of(rsp1_of),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_zf(alu_zf), .alu_of(alu_of)
  );

  // Stand-in ALU; illegal opcodes return junk so the arbiter must override them.
  function automatic logic [33:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] f;
    logic        of;
    of = 1'b0;
    case (op)
      4'd0: f = a & b;
      4'd1: f = a | b;
      4'd2: f = a ^ b;
      4'd3: f = ~(a | b);
      4'd4: begin f = a + b; of = (a[31] == b[31]) && (f[31] != a[31]); end
      4'd5: begin f = a - b; of = (a[31] != b[31]) && (f[31] != a[31]); end
      4'd6: f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7: f = a << b[4:0];
      default: return {1'b1, 1'b0, 32'hDEADBEEF};
    endcase
    return {of, (f == 32'd0), f};
  endfunction

  // Result the requester must see: {of, zf, f}
  function automatic logic [33:0] exp_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op > 4'd7) return {1'b0, 1'b1, 32'd0};
    return alu_fn(op, a, b);
  endfunction

  always_comb {alu_of, alu_zf, alu_f} = alu_fn(alu_op, alu_a, alu_b);

  typedef struct {
    logic        owner;
    logic [31:0] f;
    logic        zf;
    logic        of;
    int          c;
  } rsp_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   mode     = 0;
  rsp_t rsp_log[$];
  int   grants[$];
  int   acc_cyc[$];

  // Transaction-level model: one op in flight, age counts cycles since acceptance.
  logic        m_busy, m_owner, m_last, m_lock;
  int          m_age;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;
  logic [33:0] m_res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 3))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      default: return $urandom();
    endcase
  endfunction

  task automatic set_valid(input logic side, input logic v);
    if (side) req1_valid = v;
    else req0_valid = v;
  endtask

  task automatic new_payload(input logic side);
    logic [3:0]  op;
    logic [31:0] a, b;
    op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
    a  = rval();
    b  = rval();
    if (side) begin req1_op = op; req1_a = a; req1_b = b; end
    else begin req0_op = op; req0_a = a; req0_b = b; end
`ifdef ALU_ARB_LOCK_EN
    if (mode == 2) begin
      if (side) req1_lock = 1'($urandom_range(0, 1));
      else req0_lock = 1'($urandom_range(0, 1));
    end
`endif
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_lock = 1'b0; m_age = 0;
  endtask

  // One clock cycle: compare DUT against model, advance model, then drive next inputs.
  task automatic cycle();
    logic gv, gw, rv, rhs, lk;
    logic [3:0]  op;
    logic [31:0] a, b;
    #1;
    gv = !m_busy && (req0_valid || req1_valid);
    gw = (req0_valid && req1_valid) ? !m_last : req1_valid;
    rv = m_busy && (m_age >= 2);
    check_b("req0_ready", req0_ready, gv && !gw);
    check_b("req1_ready", req1_ready, gv && gw);
    check_b("rsp0_valid", rsp0_valid, rv && !m_owner);
    check_b("rsp1_valid", rsp1_valid, rv && m_owner);
    if (rv) begin
      check("rsp0_f", rsp0_f, m_res[31:0]);
      check("rsp1_f", rsp1_f, m_res[31:0]);
      check_b("rsp_zf", m_owner ? rsp1_zf : rsp0_zf, m_res[32]);
      check_b("rsp_of", m_owner ? rsp1_of : rsp0_of, m_res[33]);
    end
    if (m_busy) begin
      check("alu_op", 32'(alu_op), 32'(m_op));
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
    end
    op = gw ? req1_op : req0_op;
    a  = gw ? req1_a : req0_a;
    b  = gw ? req1_b : req0_b;
`ifdef ALU_ARB_LOCK_EN
    lk = gw ? req1_lock : req0_lock;
`else
    lk = 1'b0;
`endif
    rhs = rv && (m_owner ? rsp1_ready : rsp0_ready);
    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))
      rsp_log.push_back('{rsp1_valid, rsp1_valid ? rsp1_f : rsp0_f,
                          rsp1_valid ? rsp1_zf : rsp0_zf, rsp1_valid ? rsp1_of : rsp0_of, cyc});
    if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
      grants.push_back(req1_ready ? 1 : 0);
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    if (!m_busy) begin
      if (gv) begin
        m_busy = 1'b1; m_age = 1; m_owner = gw; m_op = op; m_a = a; m_b = b;
        m_res = exp_fn(op, a, b); m_lock = lk;
      end
    end else if (m_age >= 2) begin
      if (rhs) begin
        m_busy = 1'b0;
        if (!m_lock) m_last = m_owner;
      end
    end else begin
      m_age++;
    end
    @(negedge clk);
    if (mode == 2) begin
      for (int s = 0; s < 2; s++) begin
        if (gv && (gw == 1'(s))) begin
          new_payload(1'(s));
          set_valid(1'(s), 1'($urandom_range(0, 1)));
        end else if (!(s == 1 ? req1_valid : req0_valid)) begin
          if ($urandom_range(0, 2) == 0) begin
            new_payload(1'(s));
            set_valid(1'(s), 1'b1);
          end
        end else if ($urandom_range(0, 19) == 0) begin
          set_valid(1'(s), 1'b0);
        end
      end
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
    end else if (gv) begin
      if (mode == 0) set_valid(gw, 1'b0);
      else new_payload(gw);
    end
  endtask

  // Assert reset, check outputs immediately, release on the next falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_b("rst_req0_ready", req0_ready, 1'b0);
    check_b("rst_req1_ready", req1_ready, 1'b0);
    check_b("rst_rsp0_valid", rsp0_valid, 1'b0);
    check_b("rst_rsp1_valid", rsp1_valid, 1'b0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_rsp_f", rsp0_f, 32'd0);
    check_b("rst_rsp_zf", rsp0_zf, 1'b0);
    check_b("rst_rsp_of", rsp0_of, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    rsp_log.delete(); grants.delete(); acc_cyc.delete();
  endtask

  task automatic check_rsp(input string tag, input int idx, input logic owner, input logic [31:0] f,
                           input logic zf, input logic of);
    check_b(tag, rsp_log.size() > idx, 1'b1);
    if (rsp_log.size() > idx) begin
      check_b(tag, rsp_log[idx].owner, owner);
      check(tag, rsp_log[idx].f, f);
      check_b(tag, rsp_log[idx].zf, zf);
      check_b(tag, rsp_log[idx].of, of);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b1; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
`ifdef ALU_ARB_LOCK_EN
    req0_lock = 1'b0; req1_lock = 1'b0;
`endif
    model_reset();
    m_op = '0; m_a = '0; m_b = '0; m_res = '0;
    @(negedge clk);
    do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Single ADD from requester 0
    clear_logs(); mode = 0;
    req0_valid = 1'b1; req0_op = 4'd4; req0_a = 32'd5; req0_b = 32'd7;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (4) cycle();
    check_rsp("single_add", 0, 1'b0, 32'd12, 1'b0, 1'b0);
    check("single_cnt", rsp_log.size(), 1);
    if (rsp_log.size() > 0 && acc_cyc.size() > 0) check("single_latency", rsp_log[0].c - acc_cyc[0], 2);

    // Both valid out of reset: alternate grants over six ops
    req0_valid = 1'b1; req0_op = 4'd5; req0_a = 32'd3; req0_b = 32'd3;
    req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'hF0; req1_b = 32'h0F;
    do_reset();
    clear_logs(); mode = 1;
    repeat (18) cycle();
    check_rsp("tie_sub", 0, 1'b0, 32'd0, 1'b1, 1'b0);
    check_rsp("tie_or", 1, 1'b1, 32'hFF, 1'b0, 1'b0);
    check("tie_grants", grants.size(), 6);
    for (int i = 0; i < grants.size(); i++) check("tie_alternate", grants[i], i % 2);
    req0_valid = 1'b0; req1_valid = 1'b0; mode = 0;
    repeat (3) cycle();

    // Backpressure on requester 1 while requester 0 waits
    clear_logs();
    req1_valid = 1'b1; req1_op = 4'd4; req1_a = 32'd1; req1_b = 32'd2; rsp1_ready = 1'b0;
    cycle();
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 32'hF0F0; req0_b = 32'h0FF0;
    repeat (6) cycle();
    check("bp_no_grant0", grants.size(), 1);
    rsp1_ready = 1'b1;
    repeat (4) cycle();
    check_rsp("bp_rsp1", 0, 1'b1, 32'd3, 1'b0, 1'b0);
    check_rsp("bp_rsp0", 1, 1'b0, 32'hFF00, 1'b0, 1'b0);
    if (rsp_log.size() > 0 && acc_cyc.size() > 1) begin
      check("bp_stall", rsp_log[0].c - acc_cyc[0], 7);
      check("bp_next_grant", acc_cyc[1] - rsp_log[0].c, 1);
    end

    // Illegal opcode ignores the ALU
    clear_logs();
    req0_valid = 1'b1; req0_op = 4'hA; req0_a = 32'd1; req0_b = 32'd1;
    repeat (4) cycle();
    check_rsp("illegal", 0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Reset during EXEC drops the op
    clear_logs();
    req0_valid = 1'b1; req0_op = 4'd4; req0_a = 32'd9; req0_b = 32'd9;
    cycle();
    #2;
    do_reset();
    repeat (2) cycle();
    check("rst_dropped", rsp_log.size(), 0);
    req1_valid = 1'b1; req1_op = 4'd1; req1_a = 32'h1200; req1_b = 32'h0034;
    repeat (4) cycle();
    check_rsp("post_rst_req1", 0, 1'b1, 32'h1234, 1'b0, 1'b0);
    clear_logs();
    req0_valid = 1'b1; req0_op = 4'd4; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1'b1; req1_op = 4'd4; req1_a = 32'd2; req1_b = 32'd2;
    repeat (7) cycle();
    check("post_rst_tie", grants.size(), 2);
    if (grants.size() > 0) check("post_rst_tie0", grants[0], 0);

`ifdef ALU_ARB_LOCK_EN
    // Locked requester 0 keeps priority until it issues an unlocked op
    req0_valid = 1'b1; req1_valid = 1'b1; req0_lock = 1'b1; req1_lock = 1'b0;
    do_reset();
    clear_logs(); mode = 1;
    repeat (6) cycle();
    req0_lock = 1'b0;
    repeat (6) cycle();
    check("lock_grants", grants.size(), 4);
    if (grants.size() > 3) begin
      check("lock_g0", grants[0], 0);
      check("lock_g1", grants[1], 0);
      check("lock_g2", grants[2], 0);
      check("lock_g3", grants[3], 1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; mode = 0;
    repeat (3) cycle();
`endif

    // Random traffic against the model
    do_reset();
    clear_logs(); mode = 2;
    repeat (800) cycle();
    check_b("rand_activity", grants.size() > 20, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational 32-bit ALU between two requesters (e.g. execute stage and address/branch unit).
- Accepts an operation per requester through a valid/ready handshake and drives the ALU from registered operands.
- Captures F/ZF/OF into a result register and returns it on a per-requester response handshake.
- Sits between the requesters and the ALU instance; owns ALU_OP/A/B.

Parameters:
- WIDTH, 32, operand/result width
- OPW, 4, ALU opcode width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid / req1_valid  in  1  requester has an operation
- req0_ready / req1_ready  out  1  operation accepted this cycle
- req0_op / req1_op  in  OPW  ALU opcode (0..7 legal)
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- rsp0_valid / rsp1_valid  out  1  result available
- rsp0_ready / rsp1_ready  in  1  requester takes result
- rsp0_f / rsp1_f  out  WIDTH  result
- rsp0_zf, rsp0_of / rsp1_zf, rsp1_of  out  1  flags
- alu_op  out  OPW  to ALU_OP
- alu_a, alu_b  out  WIDTH  to ALU A/B
- alu_f  in  WIDTH  from ALU F
- alu_zf, alu_of  in  1  from ALU ZF/OF

Behaviour:
- Clocking and reset: one clock (clk); rst_n asynchronous, active-low. All state updates on posedge clk.
- Reset values:
  - state=IDLE, owner=0, last_grant=1 (requester 0 wins first tie).
  - alu_op/alu_a/alu_b=0, result register=0 (f=0, zf=0, of=0).
  - All ready/valid outputs 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqX_ready is combinational: asserted only for the chosen requester, only in IDLE.
  - Choice when one valid: that requester. When both valid: the requester != last_grant.
  - On handshake: latch op/a/b into alu_op/alu_a/alu_b, record owner, go to EXEC.
- EXEC (1 cycle):
  - ALU settles on registered operands.
  - At clock edge capture alu_f/alu_zf/alu_of into the result register, go to RESP.
  - Opcodes 8..15: ALU outputs are ignored; capture f=0, zf=1, of=0.
- RESP:
  - rsp<owner>_valid=1; the other rspY_valid=0.
  - rsp<owner>_f/zf/of = result register; both requesters see the same result bus value, qualified only by their own valid.
  - Held stable until rsp<owner>_ready. On handshake: last_grant<=owner, go to IDLE.
  - No new request is accepted in RESP.
- Latency: request accepted at edge N → rsp_valid high after edge N+2. Peak throughput is one op per 3 cycles with rsp_ready tied high.
- alu_op/alu_a/alu_b hold their last value outside EXEC. No other toggling.
- Requesters must hold valid and payload stable until ready. Deasserting valid before ready is allowed; the request is then simply not taken.
- rspX_ready asserted while rspX_valid=0 is ignored.
- Asynchronous reset mid-operation: the in-flight operation is dropped with no response; all outputs return to reset values immediately.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- Defined:
  - Adds inputs req0_lock, req1_lock (1 bit each).
  - If the accepted request had lock=1, last_grant is not updated at the response handshake, so the same requester keeps priority for its next request (atomic multi-op sequences).
  - Lock is sampled at acceptance only.
- Undefined: lock ports absent; last_grant always updates to owner.

Test Plan:
- Single op, req0: op=4 (ADD), a=5, b=7, rsp0_ready=1 → req0_ready at cycle 0; rsp0_valid at cycle 2 with f=12, zf=0, of=0; rsp1_valid stays 0.
- Simultaneous: both valid from reset, req0 SUB 3-3, req1 OR 0xF0|0x0F → req0 served first (f=0, zf=1), then req1 (f=0xFF); grants alternate over 6 back-to-back ops.
- Backpressure: rsp1_ready low 5 cycles after rsp1_valid → f/zf/of and valid stable; req0_valid high meanwhile gets no ready until the rsp1 handshake, then granted in the next IDLE cycle.
- Illegal opcode: req0_op=4'hA, a=1, b=1 → rsp0_f=0, zf=1, of=0.
- Reset mid-EXEC: assert rst_n=0 between edges → rsp*_valid=0, alu_a/alu_b/alu_op=0 immediately; after release, req1-only traffic is accepted normally, and a subsequent tie grants req0.
- ALU_ARB_LOCK_EN: req0_lock=1, both valid continuously → req0 granted twice consecutively; after a req0 op with lock=0, req1 is granted next.
